// File: rtl/apb5_completer_mem.sv
// apb5_completer_mem: word-addressed memory behind an APB5 completer port.
// Provides programmable wait states, byte-strobe writes, a secure-only low
// region, slave-error generation and user-signal return on the response.
// Optional feature macro: APB5_PARITY_EN adds per-byte odd parity on the
// write data (pwdatachk, checked) and the read data (prdatachk, generated).
module apb5_completer_mem #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 128,
    parameter int USER_DATA_WIDTH = DATA_WIDTH / 2,
    parameter int MEM_DEPTH       = 256,
    parameter int WAIT_STATES     = 0,
    parameter int SECURE_WORDS    = 16
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic [ADDR_WIDTH-1:0]      paddr,
    input  logic [2:0]                 pprot,
    input  logic                       pselx,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH/8-1:0]    pstrb,
    input  logic [USER_REQ_WIDTH-1:0]  pauser,
    input  logic [USER_DATA_WIDTH-1:0] pwuser,
`ifdef APB5_PARITY_EN
    input  logic [DATA_WIDTH/8-1:0]    pwdatachk,
    output logic [DATA_WIDTH/8-1:0]    prdatachk,
`endif
    output logic                       pready,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pslverr,
    output logic [USER_DATA_WIDTH-1:0] pruser,
    output logic [USER_DATA_WIDTH-1:0] pbuser
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS_WAIT, ACCESS_DONE} state_t;

    state_t                     state;
    logic [3:0]                 cnt;
    logic [DATA_WIDTH-1:0]      mem [MEM_DEPTH];

    logic                       lat_write;
    logic                       lat_err;
    logic [IDXW-1:0]            lat_idx;
    logic [BYTES-1:0]           lat_strb;
    logic [DATA_WIDTH-1:0]      lat_wdata;
    logic [USER_DATA_WIDTH-1:0] lat_ruser;
    logic [USER_DATA_WIDTH-1:0] lat_buser;

    logic [IDXW-1:0]            idx;
    logic                       err_range;
    logic                       err_align;
    logic                       err_secure;
    logic                       err_strb;
    logic                       par_err;
    logic                       err_any;
    logic                       mem_we;
    logic                       unused_bits;

    // Decode of the live setup-phase request; only consumed on the setup edge.
    assign idx        = paddr[OFF +: IDXW];
    assign err_range  = {1'b0, paddr} >= MEM_BYTES;
    assign err_align  = (paddr & ALIGN_MASK) != '0;
    assign err_secure = pprot[1] && (int'(idx) < SECURE_WORDS);
    assign err_strb   = !pwrite && (pstrb != '0);
    assign err_any    = err_range || err_align || err_secure || err_strb || par_err;
    assign mem_we     = (state == ACCESS_DONE) && pselx && penable && lat_write && !lat_err;
    assign unused_bits = ^{pprot[2], pprot[0], pauser[USER_REQ_WIDTH-1:USER_DATA_WIDTH]};

`ifdef APB5_PARITY_EN
    // Flag a write whose odd-parity check bit is wrong on any strobed byte.
    always_comb begin
        par_err = 1'b0;
        for (int k = 0; k < BYTES; k++) begin
            if (pwrite && pstrb[k] && !(^{pwdata[8*k +: 8], pwdatachk[k]})) begin
                par_err = 1'b1;
            end
        end
    end

    // Odd-parity check bits follow the registered read data (all-ones when it is 0).
    always_comb begin
        prdatachk = '1;
        for (int k = 0; k < BYTES; k++) begin
            prdatachk[k] = ~^prdata[8*k +: 8];
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // Memory array: cleared on reset, byte-strobed update on an error-free write completion.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (lat_strb[k]) begin
                    mem[lat_idx][8*k +: 8] <= lat_wdata[8*k +: 8];
                end
            end
        end
    end

    // Transfer FSM: latches the request at setup, counts wait states, drives registered response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            cnt       <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            pruser    <= '0;
            pbuser    <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_strb  <= '0;
            lat_wdata <= '0;
            lat_ruser <= '0;
            lat_buser <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pselx && !penable) begin
                        lat_write <= pwrite;
                        lat_err   <= err_any;
                        lat_idx   <= idx;
                        lat_strb  <= pstrb;
                        lat_wdata <= pwdata;
                        lat_ruser <= pwrite ? '0 : pauser[USER_DATA_WIDTH-1:0];
                        lat_buser <= pwrite ? pwuser : '0;
                        cnt       <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state   <= ACCESS_DONE;
                            pready  <= 1'b1;
                            pslverr <= err_any;
                            prdata  <= (!pwrite && !err_any) ? mem[idx] : '0;
                            pruser  <= pwrite ? '0 : pauser[USER_DATA_WIDTH-1:0];
                            pbuser  <= pwrite ? pwuser : '0;
                        end else begin
                            state   <= ACCESS_WAIT;
                        end
                    end
                end
                ACCESS_WAIT: begin
                    if (pselx && penable) begin
                        if (cnt == 4'd1) begin
                            state   <= ACCESS_DONE;
                            pready  <= 1'b1;
                            pslverr <= lat_err;
                            prdata  <= (!lat_write && !lat_err) ? mem[lat_idx] : '0;
                            pruser  <= lat_ruser;
                            pbuser  <= lat_buser;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    pruser  <= '0;
                    pbuser  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb5_completer_mem.sv
// tb_apb5_completer_mem: directed bench for apb5_completer_mem.
// Two instances share the request bus but have separate selects:
// dut0 with no wait states, dut3 with three wait states.
module tb_apb5_completer_mem;

    logic         pclk = 1'b0;
    logic         presetn;
    logic [31:0]  paddr;
    logic [2:0]   pprot;
    logic         psel0;
    logic         psel3;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [127:0] pauser;
    logic [15:0]  pwuser;

    logic         pready0, pslverr0, pready3, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [15:0]  pruser0, pbuser0, pruser3, pbuser3;

    int checks = 0;
    int errors = 0;

    logic [31:0] rdata;
    logic        slverr;
    logic [15:0] ruser;
    logic [15:0] buser;
    int          waits;

    apb5_completer_mem #(.WAIT_STATES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot),
        .pselx(psel0), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pauser(pauser), .pwuser(pwuser),
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
        .pruser(pruser0), .pbuser(pbuser0)
    );

    apb5_completer_mem #(.WAIT_STATES(3)) dut3 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot),
        .pselx(psel3), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pauser(pauser), .pwuser(pwuser),
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
        .pruser(pruser3), .pbuser(pbuser3)
    );

    // Free-running 100 MHz clock.
    always #5 pclk = ~pclk;

    // One comparison: counts it, and on mismatch counts an error and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One APB transfer to dut0 or dut3; abortAfter>0 drops the select after that many wait cycles.
    task automatic applyStimulus(input int which, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [2:0] prot, input logic [15:0] user,
                                 input int abortAfter,
                                 output logic [31:0] rd, output logic err,
                                 output logic [15:0] ru, output logic [15:0] bu,
                                 output int nwait);
        logic rdy;
        bit   done;
        rd = '0; err = 1'b0; ru = '0; bu = '0; nwait = 0; done = 1'b0;
        @(posedge pclk); #1;
        psel0   = (which == 0);
        psel3   = (which == 3);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        pauser  = {{112{1'b1}}, user};
        pwuser  = ~user;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = ~addr;
        pwdata  = ~data;
        while (!done) begin
            rdy = (which == 0) ? pready0 : pready3;
            if (rdy) begin
                rd  = (which == 0) ? prdata0  : prdata3;
                err = (which == 0) ? pslverr0 : pslverr3;
                ru  = (which == 0) ? pruser0  : pruser3;
                bu  = (which == 0) ? pbuser0  : pbuser3;
                @(posedge pclk); #1;
                done = 1'b1;
            end else begin
                nwait++;
                if (nwait == abortAfter || nwait > 40) begin
                    done = 1'b1;
                end else begin
                    @(posedge pclk); #1;
                end
            end
        end
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    // Directed sequence of steps with hand-computed expectations.
    initial begin
        presetn = 1'b0;
        paddr = '0; pprot = '0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; pauser = '0; pwuser = '0;
        repeat (3) @(posedge pclk);
        #1;
        checkOutput("reset pready",  32'(pready0),  32'd0);
        checkOutput("reset pslverr", 32'(pslverr0), 32'd0);
        checkOutput("reset prdata",  prdata0,       32'd0);
        checkOutput("reset pruser",  32'(pruser0),  32'd0);
        checkOutput("reset pbuser",  32'(pbuser0),  32'd0);
        presetn = 1'b1;

        // Zero wait states: write then read back.
        applyStimulus(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b000, 16'h1357, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("ws0 write waits",   32'(waits),  32'd0);
        checkOutput("ws0 write slverr",  32'(slverr), 32'd0);
        checkOutput("ws0 write pbuser",  32'(buser),  32'h0000ECA8);
        checkOutput("ws0 write pruser",  32'(ruser),  32'd0);
        checkOutput("idle pready",       32'(pready0), 32'd0);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 16'h2468, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("ws0 read waits",    32'(waits),  32'd0);
        checkOutput("ws0 read prdata",   rdata,       32'hDEADBEEF);
        checkOutput("ws0 read slverr",   32'(slverr), 32'd0);
        checkOutput("ws0 read pruser",   32'(ruser),  32'h00002468);
        checkOutput("ws0 read pbuser",   32'(buser),  32'd0);
        checkOutput("idle prdata",       prdata0,     32'd0);

        // Byte strobes over a known word.
        applyStimulus(0, 1'b1, 32'h80, 32'hAAAAAAAA, 4'hF, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        applyStimulus(0, 1'b1, 32'h80, 32'h11223344, 4'h5, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("strobe write slverr", 32'(slverr), 32'd0);
        applyStimulus(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("strobe readback", rdata, 32'hAA22AA44);

        // Secure region protection.
        applyStimulus(0, 1'b1, 32'h00, 32'h55AA55AA, 4'hF, 3'b010, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("nonsecure write slverr", 32'(slverr), 32'd1);
        applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("nonsecure write no update", rdata, 32'd0);
        applyStimulus(0, 1'b1, 32'h00, 32'h55AA55AA, 4'hF, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("secure write slverr", 32'(slverr), 32'd0);
        applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("secure readback", rdata, 32'h55AA55AA);
        applyStimulus(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b010, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("last secure word slverr", 32'(slverr), 32'd1);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b010, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("first open word slverr", 32'(slverr), 32'd0);
        checkOutput("first open word prdata", rdata, 32'hDEADBEEF);

        // Range, alignment and read-strobe errors.
        applyStimulus(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("out of range slverr", 32'(slverr), 32'd1);
        checkOutput("out of range prdata", rdata, 32'd0);
        applyStimulus(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("last word slverr", 32'(slverr), 32'd0);
        applyStimulus(0, 1'b0, 32'h41, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("misaligned read slverr", 32'(slverr), 32'd1);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h1, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("read strobe slverr", 32'(slverr), 32'd1);
        checkOutput("read strobe prdata", rdata, 32'd0);
        applyStimulus(0, 1'b1, 32'h82, 32'h0, 4'hF, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("misaligned write slverr", 32'(slverr), 32'd1);
        applyStimulus(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("misaligned write no update", rdata, 32'hAA22AA44);

        // Three wait states.
        applyStimulus(3, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("ws3 write waits", 32'(waits), 32'd3);
        applyStimulus(3, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 16'hA5A5, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("ws3 read waits",  32'(waits), 32'd3);
        checkOutput("ws3 read prdata", rdata,      32'hCAFEF00D);
        checkOutput("ws3 read pruser", 32'(ruser), 32'h0000A5A5);

        // Select dropped during the wait phase: no write, FSM back in IDLE.
        applyStimulus(3, 1'b1, 32'h44, 32'h12345678, 4'hF, 3'b000, 16'h0, 1, rdata, slverr, ruser, buser, waits);
        checkOutput("abort pready", 32'(pready3), 32'd0);
        applyStimulus(3, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("abort no write", rdata,       32'd0);
        checkOutput("abort then waits", 32'(waits), 32'd3);

        // Reset mid-transfer: dut3 is waiting, dut0 is presenting its response.
        @(posedge pclk); #1;
        psel0 = 1'b1; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h48; pwdata = 32'h0BADF00D; pstrb = 4'hF; pprot = 3'b000; pwuser = 16'hBEEF;
        @(posedge pclk); #1;
        penable = 1'b1;
        checkOutput("pre-reset pready0", 32'(pready0), 32'd1);
        checkOutput("pre-reset pbuser0", 32'(pbuser0), 32'h0000BEEF);
        presetn = 1'b0;
        #1;
        checkOutput("async reset pready0", 32'(pready0), 32'd0);
        checkOutput("async reset pbuser0", 32'(pbuser0), 32'd0);
        checkOutput("async reset pready3", 32'(pready3), 32'd0);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        applyStimulus(3, 1'b0, 32'h48, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("reset aborted write", rdata, 32'd0);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 16'h0, 0, rdata, slverr, ruser, buser, waits);
        checkOutput("reset clears memory", rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
